dmem_port_arbiter: RTL and testbench

// - Shares the single data_mem port between the CPU core load/store path and the AXI-Lite host path.
// - Sits between those two requesters and data_mem:
//   - combinational read;
//   - write committed on the rising clk edge while MemRW=1.
// - Replaces the ad-hoc AWVALID mux. Provides:
//   - CPU-priority arbitration with bounded host starvation;
//   - a host-exclusive mode for program/data loading;
//   - registered read returns with a 1-cycle latency.

---
 rtl/phx_mem_pkg.sv | 23 ++
 rtl/dmem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phx_mem_pkg.sv
// phx_mem_pkg -- shared types and constants for the data-memory port path.
//   arb_state_t : arbitration FSM states of dmem_port_arbiter
//   F3_*        : RV32 load/store funct3 encodings understood by data_mem
//   F3_WORD     : full 32-bit access, used for every host access
package phx_mem_pkg;

  typedef enum logic [1:0] {
    SHARED,
    DRAIN,
    HOST_EXCL
  } arb_state_t;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter -- shares the single data_mem port between the CPU
// load/store path and the AXI-Lite host path.
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/funct3 -> cpu_gnt (comb), cpu_rvalid/cpu_rdata (reg)
//   host_req/we/addr/wdata   -> host_gnt (comb), host_rvalid/host_rdata (reg)
//   host_lock -> host_locked : host-exclusive mode request / status
//   mem_addr/wdata/funct3/rw -> data_mem, mem_rdata <- data_mem (comb read)
// CPU has priority; the host is forced ahead after MAX_WAIT refused cycles.
module dmem_port_arbiter
  import phx_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [2:0]        cpu_funct3,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              host_locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned    CNT_W      = 4;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  // Grants: at most one per cycle, none while in reset.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      unique case (state)
        SHARED: begin
          if (cpu_req && !(host_req && wait_cnt == WAIT_LIMIT))
            cpu_gnt = 1'b1;
          else
            host_gnt = host_req;
        end
        DRAIN, HOST_EXCL: host_gnt = host_req;
        default: ;
      endcase
    end
  end

  // Port mux: idle cycles present the CPU fields with writes disabled.
  always_comb begin
    mem_rw = (cpu_gnt && cpu_we) || (host_gnt && host_we);
    if (host_gnt) begin
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_funct3 = F3_WORD;
    end else begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHARED;
      wait_cnt    <= '0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      host_locked <= 1'b0;
    end else begin
      cpu_rvalid  <= cpu_gnt && !cpu_we;
      host_rvalid <= host_gnt && !host_we;
      if (cpu_gnt && !cpu_we)
        cpu_rdata <= mem_rdata;
      if (host_gnt && !host_we)
        host_rdata <= mem_rdata;

      if (host_req && !host_gnt) begin
        if (wait_cnt != WAIT_LIMIT)
          wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      unique case (state)
        SHARED: begin
          if (host_lock)
            state <= DRAIN;
        end
        // DRAIN grants nothing to the CPU, so the only load that can still
        // be outstanding is the one whose rvalid is shown this very cycle;
        // one DRAIN cycle is therefore always enough.
        DRAIN: begin
          if (!host_lock) begin
            state <= SHARED;
          end else begin
            state       <= HOST_EXCL;
            host_locked <= 1'b1;
          end
        end
        HOST_EXCL: begin
          if (!host_lock) begin
            state       <= SHARED;
            host_locked <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        default: state <= SHARED;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter -- directed stimulus with a read-return scoreboard.
// Stimulus pushes expected load data (and grant cycle) into per-port queues;
// an independent negedge monitor pops and compares on every rvalid.
module tb_dmem_port_arbiter;
  import phx_mem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_funct3;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          host_lock, host_locked;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_funct3;
  logic          mem_rw;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .host_locked(host_locked),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  // data_mem stand-in: combinational read, write on the edge while MemRW=1.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_rw) mem[mem_addr[11:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t cpu_q[$];
  exp_t host_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: every rvalid must match the oldest expectation, one cycle late.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) begin
        chkb("cpu_rvalid_unexpected", 1'b1, 1'b0);
      end else begin
        e = cpu_q.pop_front();
        chk("cpu_rdata", cpu_rdata, e.data);
        chk("cpu_rlatency", cyc, e.cyc + 1);
      end
    end
    if (host_rvalid) begin
      if (host_q.size() == 0) begin
        chkb("host_rvalid_unexpected", 1'b1, 1'b0);
      end else begin
        e = host_q.pop_front();
        chk("host_rdata", host_rdata, e.data);
        chk("host_rlatency", cyc, e.cyc + 1);
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; checks run 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cpu(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc;
    cpu_q.push_back(e);
  endtask

  task automatic push_host(input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc;
    host_q.push_back(e);
  endtask

  task automatic access(input bit is_host, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    if (is_host) begin
      host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      cpu_funct3 = we ? F3_SW : F3_LW; cpu_req = 1'b1;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      #2;
      if (is_host ? host_gnt : cpu_gnt) begin
        got = 1'b1;
        chkb("acc_mem_rw", mem_rw, we);
        chk("acc_mem_addr", mem_addr, addr);
        if (we) chk("acc_mem_wdata", mem_wdata, wdata);
        if (is_host) chk("acc_host_funct3", {29'd0, mem_funct3}, {29'd0, F3_WORD});
        if (!we) begin
          if (is_host) push_host(exp_rd);
          else push_cpu(exp_rd);
        end
      end else begin
        waited++;
      end
      tick();
    end
    chkb("acc_grant_timeout", got, 1'b1);
    if (is_host) host_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  int w;
  logic [9:0] pat;

  initial begin
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h800; cpu_wdata = 32'h0;
    cpu_funct3 = F3_SW;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h804; host_wdata = 32'h0;
    host_lock = 1'b0;

    // Reset: no grants, no writes even with both sides asking to write.
    tick();
    #2;
    chkb("rst_cpu_gnt", cpu_gnt, 1'b0);
    chkb("rst_host_gnt", host_gnt, 1'b0);
    chkb("rst_mem_rw", mem_rw, 1'b0);
    tick();
    rst = 1'b0; cpu_req = 1'b0; host_req = 1'b0;
    #2;
    chkb("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chkb("rst_host_rvalid", host_rvalid, 1'b0);
    chkb("rst_host_locked", host_locked, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    tick();

    // Preload through the host path.
    access(1'b1, 1'b1, 32'h804, 32'h0000_0055, 32'h0, w);
    access(1'b1, 1'b1, 32'h900, 32'hA5A5_0900, 32'h0, w);
    access(1'b1, 1'b1, 32'h904, 32'h5A5A_0904, 32'h0, w);

    // CPU only: store then load, granted on both cycles.
    access(1'b0, 1'b1, 32'h800, 32'hDEAD_BEEF, 32'h0, w);
    chk("cpu_store_wait", w, 0);
    access(1'b0, 1'b0, 32'h800, 32'h0, 32'hDEAD_BEEF, w);
    chk("cpu_load_wait", w, 0);
    access(1'b1, 1'b0, 32'h904, 32'h0, 32'h5A5A_0904, w);

    // Same-address collision: CPU read wins and sees the old value.
    cpu_we = 1'b0; cpu_addr = 32'h804; cpu_funct3 = F3_LW; cpu_req = 1'b1;
    host_we = 1'b1; host_addr = 32'h804; host_wdata = 32'h11; host_req = 1'b1;
    #2;
    chkb("coll_cpu_gnt", cpu_gnt, 1'b1);
    chkb("coll_host_gnt", host_gnt, 1'b0);
    chkb("coll_mem_rw", mem_rw, 1'b0);
    push_cpu(32'h0000_0055);
    tick();
    cpu_req = 1'b0;
    #2;
    chkb("coll_host_retry_gnt", host_gnt, 1'b1);
    chkb("coll_host_retry_rw", mem_rw, 1'b1);
    chk("coll_host_retry_wdata", mem_wdata, 32'h11);
    tick();
    host_req = 1'b0;
    access(1'b0, 1'b0, 32'h804, 32'h0, 32'h0000_0011, w);

    // Contention: CPU four cycles, host on the fifth, repeating.
    pat = 10'b10000_10000;
    cpu_we = 1'b0; cpu_addr = 32'h900; cpu_funct3 = F3_LW; cpu_req = 1'b1;
    host_we = 1'b0; host_addr = 32'h904; host_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chkb("cont_cpu_gnt", cpu_gnt, !pat[i]);
      chkb("cont_host_gnt", host_gnt, pat[i]);
      if (pat[i]) push_host(32'h5A5A_0904);
      else push_cpu(32'hA5A5_0900);
      tick();
    end
    host_req = 1'b0;

    // Lock during a CPU load stream.
    #2;
    chkb("lock_pre_cpu_gnt", cpu_gnt, 1'b1);
    push_cpu(32'hA5A5_0900);
    tick();
    host_lock = 1'b1;
    #2;
    chkb("lock_shared_cpu_gnt", cpu_gnt, 1'b1);
    push_cpu(32'hA5A5_0900);
    tick();
    #2;
    chkb("drain_cpu_gnt", cpu_gnt, 1'b0);
    chkb("drain_host_locked", host_locked, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      host_we = 1'b1; host_addr = 32'hA00 + 32'(4 * i);
      host_wdata = 32'h1000 + 32'(i); host_req = 1'b1;
      #2;
      chkb("excl_host_locked", host_locked, 1'b1);
      chkb("excl_cpu_gnt", cpu_gnt, 1'b0);
      chkb("excl_host_gnt", host_gnt, 1'b1);
      chkb("excl_mem_rw", mem_rw, 1'b1);
      chk("excl_mem_addr", mem_addr, 32'hA00 + 32'(4 * i));
      tick();
    end
    host_req = 1'b0; host_lock = 1'b0;
    #2;
    chkb("unlock_last_cpu_gnt", cpu_gnt, 1'b0);
    tick();
    #2;
    chkb("unlock_cpu_gnt", cpu_gnt, 1'b1);
    chkb("unlock_host_locked", host_locked, 1'b0);
    push_cpu(32'hA5A5_0900);
    tick();
    cpu_req = 1'b0;
    access(1'b0, 1'b0, 32'hA14, 32'h0, 32'h0000_1005, w);
    access(1'b0, 1'b0, 32'hA3C, 32'h0, 32'h0000_100F, w);

    // Reset right after a granted load, with the host already refused once.
    cpu_we = 1'b0; cpu_addr = 32'h800; cpu_funct3 = F3_LW; cpu_req = 1'b1;
    host_we = 1'b0; host_addr = 32'h904; host_req = 1'b1;
    #2;
    chkb("prerst_cpu_gnt", cpu_gnt, 1'b1);
    push_cpu(32'hDEAD_BEEF);
    tick();
    rst = 1'b1; cpu_we = 1'b1;
    #2;
    chkb("midrst_cpu_gnt", cpu_gnt, 1'b0);
    chkb("midrst_host_gnt", host_gnt, 1'b0);
    chkb("midrst_mem_rw", mem_rw, 1'b0);
    tick();
    rst = 1'b0; cpu_we = 1'b0;
    #2;
    chkb("postrst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("postrst_cpu_rdata", cpu_rdata, 32'h0);
    chkb("postrst_host_locked", host_locked, 1'b0);
    pat = 10'b00000_10000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) #2;
      chkb("postrst_cpu_gnt", cpu_gnt, !pat[i]);
      chkb("postrst_host_gnt", host_gnt, pat[i]);
      if (pat[i]) push_host(32'h5A5A_0904);
      else push_cpu(32'hDEAD_BEEF);
      tick();
    end
    cpu_req = 1'b0; host_req = 1'b0;

    // Idle: no writes, no returns, read registers keep their values.
    tick();
    for (int i = 0; i < 10; i++) begin
      #2;
      chkb("idle_mem_rw", mem_rw, 1'b0);
      chkb("idle_cpu_rvalid", cpu_rvalid, 1'b0);
      chkb("idle_host_rvalid", host_rvalid, 1'b0);
      chk("idle_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("idle_host_rdata", host_rdata, 32'h5A5A_0904);
      tick();
    end

    tick();
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("host_q_drained", host_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
